// File: rtl/fwd_pkg.sv
// Shared definitions for the ordered forwarder scheduler.
// Packet-length width rule and FSM state encoding.
package fwd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_FWD  = 2'd2,
        ST_GAP  = 2'd3
    } fwd_state_e;

    // A packet may fill the whole packetmem, so length needs one extra bit.
    function automatic int plen_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/fwd_order_fifo.sv
// Order FIFO holding dispatched VM indices, first-word-fall-through head.
// Full/empty come from an occupancy counter, not pointer equality.
module fwd_order_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       head,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    rd_q;
    logic [PW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (PW+1)'(DEPTH));
    assign count   = cnt_q;
    assign head    = mem_q[rd_q];
    // Space is judged before any same-cycle pop.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PW'(1);
            if (do_pop)  rd_q <= rd_q + PW'(1);
            cnt_q <= cnt_q + {{PW{1'b0}}, do_push}
                           - {{PW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/fwd_order_sched.sv
// Ordered N:1 scheduler granting the shared forwarder to filter VMs
// strictly in snoopsplit dispatch order.
module fwd_order_sched
    import fwd_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 9,
    parameter int N_VMS       = 4,
    parameter int SEL_WIDTH   = 2,
    parameter int ORDER_DEPTH = 8,
    localparam int PLEN_WIDTH = plen_width(ADDR_WIDTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        dispatch_valid,
    input  logic [SEL_WIDTH-1:0]        dispatch_vm,
    input  logic [N_VMS-1:0]            vm_drop,
    input  logic [N_VMS-1:0]            ready_for_forwarder_vm,
    input  logic [N_VMS*PLEN_WIDTH-1:0] len_to_forwarder_vm,
    input  logic [N_VMS*DATA_WIDTH-1:0] forwarder_rd_data_vm,
    output logic [ADDR_WIDTH-1:0]       forwarder_rd_addr_vm,
    output logic [N_VMS-1:0]            forwarder_rd_en_vm,
    output logic [N_VMS-1:0]            forwarder_done_vm,
    input  logic [ADDR_WIDTH-1:0]       forwarder_rd_addr,
    input  logic                        forwarder_rd_en,
    input  logic                        forwarder_done,
    output logic [DATA_WIDTH-1:0]       forwarder_rd_data,
    output logic                        ready_for_forwarder,
    output logic [PLEN_WIDTH-1:0]       len_to_forwarder,
    output logic                        err_overflow,
    output logic                        err_redispatch
);

    localparam int CW = $clog2(ORDER_DEPTH) + 1;

    fwd_state_e           state_q;
    logic [SEL_WIDTH-1:0] sel_q;
    logic [N_VMS-1:0]     outstanding_q, outstanding_d;
    logic [N_VMS-1:0]     drop_pending_q, drop_pending_d;
    logic                 err_ovf_q;
    logic                 err_redisp_q;

    logic [SEL_WIDTH-1:0] head;
    logic                 empty;
    logic                 full;
    logic [CW-1:0]        count;
    logic                 push_acc;
    logic                 retire_drop;
    logic                 retire_fwd;
    logic                 pop;
    logic                 in_fwd;
    logic [N_VMS-1:0]     push_mask;
    logic [N_VMS-1:0]     retire_mask;

    fwd_order_fifo #(
        .WIDTH (SEL_WIDTH),
        .DEPTH (ORDER_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (dispatch_valid),
        .pop   (pop),
        .din   (dispatch_vm),
        .head  (head),
        .empty (empty),
        .full  (full),
        .count (count)
    );

    assign in_fwd      = (state_q == ST_FWD);
    assign push_acc    = dispatch_valid && !full;
    assign retire_drop = (state_q == ST_WAIT) && !empty
                         && drop_pending_q[head];
    assign retire_fwd  = in_fwd && forwarder_done;
    assign pop         = retire_drop || retire_fwd;

    assign push_mask   = push_acc ? (N_VMS'(1) << dispatch_vm) : '0;
    assign retire_mask = retire_fwd  ? (N_VMS'(1) << sel_q) :
                         retire_drop ? (N_VMS'(1) << head)  : '0;

    // A new dispatch or drop in the retire cycle belongs to the next packet.
    assign outstanding_d  = (outstanding_q & ~retire_mask) | push_mask;
    assign drop_pending_d = (drop_pending_q & ~retire_mask) | vm_drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            sel_q          <= '0;
            outstanding_q  <= '0;
            drop_pending_q <= '0;
            err_ovf_q      <= 1'b0;
            err_redisp_q   <= 1'b0;
        end else begin
            outstanding_q  <= outstanding_d;
            drop_pending_q <= drop_pending_d;
            if (dispatch_valid && full)
                err_ovf_q <= 1'b1;
            if (push_acc && outstanding_q[dispatch_vm])
                err_redisp_q <= 1'b1;
            unique case (state_q)
                ST_IDLE: begin
                    if (!empty) state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (retire_drop) begin
                        if (count == CW'(1) && !push_acc)
                            state_q <= ST_IDLE;
                    end else if (empty) begin
                        state_q <= ST_IDLE;
                    end else if (ready_for_forwarder_vm[head]) begin
                        sel_q   <= head;
                        state_q <= ST_FWD;
                    end
                end
                ST_FWD: begin
                    if (forwarder_done) state_q <= ST_GAP;
                end
                ST_GAP: begin
                    state_q <= empty ? ST_IDLE : ST_WAIT;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ready_for_forwarder = 1'b0;
        len_to_forwarder    = '0;
        forwarder_rd_data   = '0;
        forwarder_rd_en_vm  = '0;
        forwarder_done_vm   = '0;
        if (in_fwd) begin
            ready_for_forwarder = ready_for_forwarder_vm[sel_q];
            len_to_forwarder    =
                len_to_forwarder_vm[int'(sel_q)*PLEN_WIDTH +: PLEN_WIDTH];
            forwarder_rd_data   =
                forwarder_rd_data_vm[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
            forwarder_rd_en_vm[sel_q] = forwarder_rd_en;
            forwarder_done_vm[sel_q]  = forwarder_done;
        end
    end

    assign forwarder_rd_addr_vm = rst ? '0 : forwarder_rd_addr;
    assign err_overflow         = err_ovf_q;
    assign err_redispatch       = err_redisp_q;

endmodule

// File: tb/tb_fwd_order_sched.sv
// Bench for fwd_order_sched: directed scenarios plus randomized batches
// checked against a dispatch-order queue model.
module tb_fwd_order_sched;

    localparam int N  = 16;
    localparam int SW = 4;
    localparam int AW = 9;
    localparam int PW = AW + 1;
    localparam int DW = 64;
    localparam int D  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          dispatch_valid;
    logic [SW-1:0] dispatch_vm;
    logic [N-1:0]  vm_drop;
    logic [N-1:0]  rdy;
    logic [N*PW-1:0] len_bus;
    logic [N*DW-1:0] data_bus;
    logic [AW-1:0] addr_vm;
    logic [N-1:0]  rd_en_vm;
    logic [N-1:0]  done_vm;
    logic [AW-1:0] f_addr;
    logic          f_en;
    logic          f_done;
    logic [DW-1:0] data;
    logic          rff;
    logic [PW-1:0] len;
    logic          err_ovf;
    logic          err_rd;

    logic [PW-1:0] len_tab [N];
    logic [DW-1:0] data_tab [N];

    int n_chk;
    int n_err;
    logic flag;
    int perm [N];
    int disp_t [N];
    int drop_t [N];
    int rdy_t [N];
    bit is_drop [N];
    int exp_q [$];
    int k, t, tmp, last_t, c, gvm, done_at, clr_at, clr_vm;
    bit busy;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            len_bus[i*PW +: PW]  = len_tab[i];
            data_bus[i*DW +: DW] = data_tab[i];
        end
    end

    fwd_order_sched #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .N_VMS       (N),
        .SEL_WIDTH   (SW),
        .ORDER_DEPTH (D)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .dispatch_valid         (dispatch_valid),
        .dispatch_vm            (dispatch_vm),
        .vm_drop                (vm_drop),
        .ready_for_forwarder_vm (rdy),
        .len_to_forwarder_vm    (len_bus),
        .forwarder_rd_data_vm   (data_bus),
        .forwarder_rd_addr_vm   (addr_vm),
        .forwarder_rd_en_vm     (rd_en_vm),
        .forwarder_done_vm      (done_vm),
        .forwarder_rd_addr      (f_addr),
        .forwarder_rd_en        (f_en),
        .forwarder_done         (f_done),
        .forwarder_rd_data      (data),
        .ready_for_forwarder    (rff),
        .len_to_forwarder       (len),
        .err_overflow           (err_ovf),
        .err_redispatch         (err_rd)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        dispatch_valid = 1'b0;
        dispatch_vm    = '0;
        vm_drop        = '0;
        rdy            = '0;
        f_en           = 1'b0;
        f_done         = 1'b0;
        f_addr         = '0;
    endtask

    task automatic do_reset();
        clr_in();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        clr_in();
        for (int i = 0; i < N; i++) begin
            len_tab[i]  = PW'(i * 37 + 5);
            data_tab[i] = {32'hDA7A0000 | 32'(i), 32'(i) * 32'h01234567};
        end
        rst    = 1'b1;
        f_addr = 9'h1AB;
        tick();
        tick();
        #1;
        chk("rst_addr", addr_vm, 0);
        chk("rst_rff", rff, 0);
        chk("rst_len", len, 0);
        chk("rst_data", data, 0);
        chk("rst_state", dut.state_q, 0);
        chk("rst_cnt", dut.u_fifo.cnt_q, 0);
        chk("rst_err", {err_ovf, err_rd}, 0);
        rst = 1'b0;
        #1;
        chk("addr_pass", addr_vm, 9'h1AB);
        f_addr = '0;

        // In-order forwarding: VM0 ready early must not jump VM2.
        flag = 1'b0;
        for (int cc = 0; cc < 30; cc++) begin
            tick();
            dispatch_valid = (cc < 2);
            dispatch_vm    = (cc == 0) ? SW'(2) : SW'(0);
            if (cc == 5)  rdy[0] = 1'b1;
            if (cc == 20) rdy[2] = 1'b1;
            if (cc == 24) rdy[2] = 1'b0;
            if (cc == 26) rdy[0] = 1'b0;
            f_en   = (cc == 21);
            f_done = (cc == 22) || (cc == 25);
            #1;
            if (cc < 21 && rff) flag = 1'b1;
            if (cc == 3) chk("io_cnt", dut.u_fifo.cnt_q, 2);
            if (cc == 21) begin
                chk("io_rdy2", rff, 1);
                chk("io_len2", len, len_tab[2]);
                chk("io_data2", data, data_tab[2]);
                chk("io_rden2", rd_en_vm, 16'h0004);
            end
            if (cc == 22) chk("io_done2", done_vm, 16'h0004);
            if (cc == 23 || cc == 24) chk("io_gap", rff, 0);
            if (cc == 25) begin
                chk("io_rdy0", rff, 1);
                chk("io_len0", len, len_tab[0]);
                chk("io_data0", data, data_tab[0]);
                chk("io_done0", done_vm, 16'h0001);
            end
        end
        chk("io_early", flag, 0);
        chk("io_state", dut.state_q, 0);
        chk("io_out", dut.outstanding_q, 0);

        // Head drop: VM1 retired without grant, VM3 then served.
        flag = 1'b0;
        for (int cc = 0; cc < 12; cc++) begin
            tick();
            dispatch_valid = (cc < 2);
            dispatch_vm    = (cc == 0) ? SW'(1) : SW'(3);
            vm_drop        = (cc == 3) ? 16'h0002 : 16'h0000;
            if (cc == 3) rdy[3] = 1'b1;
            if (cc == 8) rdy[3] = 1'b0;
            f_done = (cc >= 2 && cc <= 6);
            #1;
            if (done_vm[1] || (cc < 6 && done_vm != '0)) flag = 1'b1;
            if (cc == 5) chk("hd_out1", dut.outstanding_q[1], 0);
            if (cc == 6) begin
                chk("hd_rdy3", rff, 1);
                chk("hd_len3", len, len_tab[3]);
                chk("hd_done3", done_vm, 16'h0008);
            end
        end
        chk("hd_nodone1", flag, 0);
        chk("hd_state", dut.state_q, 0);

        // Non-head VM1 drops while VM0 is being forwarded.
        flag = 1'b0;
        for (int cc = 0; cc < 12; cc++) begin
            tick();
            dispatch_valid = (cc < 2);
            dispatch_vm    = (cc == 0) ? SW'(0) : SW'(1);
            if (cc == 0) rdy[0] = 1'b1;
            if (cc == 6) rdy[0] = 1'b0;
            vm_drop = (cc == 4) ? 16'h0002 : 16'h0000;
            f_done  = (cc == 5);
            #1;
            if (cc == 3) chk("ed_grant0", rff, 1);
            if (cc == 5) chk("ed_done0", done_vm, 16'h0001);
            if ((cc > 5 && rff) || done_vm[1]) flag = 1'b1;
            if (cc == 7) chk("ed_wait", dut.state_q, 1);
            if (cc == 8) begin
                chk("ed_idle", dut.state_q, 0);
                chk("ed_cnt", dut.u_fifo.cnt_q, 0);
            end
        end
        chk("ed_nogrant1", flag, 0);

        // Overflow: nine distinct dispatches into eight entries.
        for (int cc = 0; cc < 10; cc++) begin
            tick();
            dispatch_valid = (cc < 9);
            dispatch_vm    = SW'(cc);
            #1;
            if (cc == 8) begin
                chk("ov_cnt8", dut.u_fifo.cnt_q, 8);
                chk("ov_pre", err_ovf, 0);
            end
        end
        chk("ov_cnt", dut.u_fifo.cnt_q, 8);
        chk("ov_err", err_ovf, 1);
        chk("ov_rd", err_rd, 0);
        chk("ov_out", dut.outstanding_q, 16'h00FF);
        flag = 1'b0;
        for (int cc = 0; cc < 14; cc++) begin
            tick();
            vm_drop = (cc == 0) ? 16'h01FF : 16'h0000;
            #1;
            if (rff || done_vm != '0) flag = 1'b1;
        end
        chk("ov_drain", dut.u_fifo.cnt_q, 0);
        chk("ov_nogrant", flag, 0);
        chk("ov_state", dut.state_q, 0);
        chk("ov_dp", dut.drop_pending_q, 16'h0100);
        do_reset();

        // Redispatch, then a push in the same cycle as a done.
        for (int cc = 0; cc < 10; cc++) begin
            tick();
            dispatch_valid = (cc < 2) || (cc == 4);
            dispatch_vm    = (cc < 2) ? SW'(2) : SW'(5);
            if (cc == 2) rdy[2] = 1'b1;
            if (cc == 8) rdy[2] = 1'b0;
            f_done = (cc == 4) || (cc == 7);
            #1;
            if (cc == 2) begin
                chk("rd_err", err_rd, 1);
                chk("rd_cnt", dut.u_fifo.cnt_q, 2);
            end
            if (cc == 4) chk("pp_before", dut.u_fifo.cnt_q, 2);
            if (cc == 5) chk("pp_after", dut.u_fifo.cnt_q, 2);
            if (cc == 7) begin
                chk("rd_rdy2b", rff, 1);
                chk("rd_done2b", done_vm, 16'h0004);
            end
        end
        chk("rd_ovf", err_ovf, 0);
        do_reset();

        // Asynchronous reset in the middle of a packet.
        for (int cc = 0; cc < 4; cc++) begin
            tick();
            dispatch_valid = (cc == 0);
            dispatch_vm    = SW'(3);
            if (cc == 0) rdy[3] = 1'b1;
            f_en   = (cc == 3);
            f_addr = 9'h055;
            #1;
            if (cc == 3) begin
                chk("rm_rff", rff, 1);
                chk("rm_rden", rd_en_vm, 16'h0008);
            end
        end
        #1;
        rst    = 1'b1;
        f_done = 1'b1;
        #1;
        chk("rm_out", {rff, rd_en_vm, done_vm}, 0);
        chk("rm_ld", {len, data, addr_vm}, 0);
        f_done = 1'b0;
        f_en   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rm_state", dut.state_q, 0);
        chk("rm_cnt", dut.u_fifo.cnt_q, 0);
        chk("rm_outst", dut.outstanding_q, 0);
        for (int cc = 0; cc < 7; cc++) begin
            tick();
            dispatch_valid = (cc == 0);
            f_done         = (cc == 3);
            if (cc == 4) rdy[3] = 1'b0;
            #1;
            if (cc == 3) begin
                chk("rm_again", rff, 1);
                chk("rm_len", len, len_tab[3]);
                chk("rm_done", done_vm, 16'h0008);
            end
        end
        chk("rm_end", dut.state_q, 0);

        // Randomized batches of distinct VMs against a dispatch-order queue.
        for (int b = 0; b < 40; b++) begin
            clr_in();
            for (int i = 0; i < N; i++) begin
                perm[i]     = i;
                len_tab[i]  = PW'($urandom);
                data_tab[i] = {$urandom, $urandom};
            end
            for (int i = N - 1; i > 0; i--) begin
                tmp = $urandom_range(0, i);
                gvm = perm[i];
                perm[i] = perm[tmp];
                perm[tmp] = gvm;
            end
            k = $urandom_range(1, 8);
            t = 0;
            last_t = 0;
            exp_q.delete();
            for (int j = 0; j < k; j++) begin
                t = t + $urandom_range(1, 3);
                disp_t[perm[j]]  = t;
                is_drop[perm[j]] = ($urandom_range(0, 3) == 0);
                drop_t[perm[j]]  = t + $urandom_range(0, 12);
                rdy_t[perm[j]]   = t + $urandom_range(1, 12);
                if (drop_t[perm[j]] > last_t) last_t = drop_t[perm[j]];
                if (rdy_t[perm[j]] > last_t)  last_t = rdy_t[perm[j]];
                if (!is_drop[perm[j]]) exp_q.push_back(perm[j]);
            end
            busy   = 1'b0;
            clr_at = -1;
            clr_vm = 0;
            c      = 0;
            while (1) begin
                tick();
                dispatch_valid = 1'b0;
                vm_drop = '0;
                f_en    = 1'b0;
                f_done  = 1'b0;
                for (int j = 0; j < k; j++) begin
                    tmp = perm[j];
                    if (disp_t[tmp] == c) begin
                        dispatch_valid = 1'b1;
                        dispatch_vm    = SW'(tmp);
                    end
                    if (is_drop[tmp] && drop_t[tmp] == c) vm_drop[tmp] = 1'b1;
                    if (!is_drop[tmp] && rdy_t[tmp] == c) rdy[tmp] = 1'b1;
                end
                if (c == clr_at) rdy[clr_vm] = 1'b0;
                #1;
                if (!busy && rff) begin
                    if (exp_q.size() == 0) begin
                        chk("rnd_spurious", rff, 0);
                    end else begin
                        gvm     = exp_q.pop_front();
                        busy    = 1'b1;
                        done_at = c + $urandom_range(0, 3);
                        f_en    = 1'b1;
                        f_addr  = AW'($urandom);
                        #1;
                        chk("rnd_rden", rd_en_vm, 64'(1) << gvm);
                        chk("rnd_len", len, len_tab[gvm]);
                        chk("rnd_data", data, data_tab[gvm]);
                        chk("rnd_addr", addr_vm, f_addr);
                    end
                end
                if (busy && c == done_at) begin
                    f_done = 1'b1;
                    f_en   = 1'b0;
                    #1;
                    chk("rnd_done", done_vm, 64'(1) << gvm);
                    busy   = 1'b0;
                    clr_at = c + 1;
                    clr_vm = gvm;
                end
                c++;
                if (c > last_t + 1 && c > clr_at && !busy &&
                    exp_q.size() == 0 && dut.state_q == 0 &&
                    dut.u_fifo.cnt_q == 0)
                    break;
                if (c > 400) begin
                    chk("rnd_timeout", c, 0);
                    break;
                end
            end
            chk("rnd_outst", dut.outstanding_q, 0);
            chk("rnd_dp", dut.drop_pending_q, 0);
        end
        chk("rnd_err", {err_ovf, err_rd}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
